// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch in flight, buffers returned
// words in a 2-entry {pc, inst} queue and presents one instruction per cycle to decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        outstanding_q, outstanding_d;

  logic [1:0]  count_q, count_d;
  logic [31:0] q_pc_q   [BUF_DEPTH];
  logic [31:0] q_pc_d   [BUF_DEPTH];
  logic [31:0] q_inst_q [BUF_DEPTH];
  logic [31:0] q_inst_d [BUF_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        credit_ok;
  logic        accept;
  logic        push;
  logic        pop;
  logic        wr_sel;

  // Request only while queued plus in-flight words leave room in the buffer.
  always_comb begin
    credit_ok   = ({1'b0, count_q} + {2'b00, outstanding_q}) < 3'(BUF_DEPTH);
    imem_req_o  = rst && (state_q == StReq) && credit_ok && !redirect_i;
    imem_addr_o = fetch_pc_q;
    accept      = imem_req_o && imem_ready_i;
    push        = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    pop         = !redirect_i && !stall_i && (count_q != 2'd0);
    wr_sel      = pop ? 1'b0 : count_q[0];
  end

  // Fetch FSM and program counter.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;

    unique case (state_q)
      StReq: begin
        if (accept) begin
          state_d       = StWait;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          req_pc_d      = fetch_pc_q;
          outstanding_d = 1'b1;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          state_d       = StReq;
          outstanding_d = 1'b0;
        end else if (redirect_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid_i) begin
          state_d       = StReq;
          outstanding_d = 1'b0;
        end
      end
      default: begin
        state_d       = StReq;
        outstanding_d = 1'b0;
      end
    endcase

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
    end
  end

  // Fetch queue: entry 0 is the head; a pop shifts entry 1 down.
  always_comb begin
    count_d  = count_q;
    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;

    if (redirect_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        q_pc_d[0]   = q_pc_q[1];
        q_inst_d[0] = q_inst_q[1];
      end
      if (push) begin
        q_pc_d[wr_sel]   = req_pc_q;
        q_inst_d[wr_sel] = imem_rdata_i;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Output stage toward decode; pc_o holds across bubbles and flushes.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;

    if (redirect_i) begin
      inst_d  = 32'h0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (count_q != 2'd0) begin
        pc_d    = q_pc_q[0];
        inst_d  = q_inst_q[0];
        valid_d = 1'b1;
      end else begin
        inst_d  = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StReq;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= 32'h0;
      outstanding_q <= 1'b0;
      count_q       <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_pc_q[i]   <= 32'h0;
        q_inst_q[i] <= 32'h0;
      end
      pc_q          <= 32'h0;
      inst_q        <= 32'h0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      q_pc_q        <= q_pc_d;
      q_inst_q      <= q_inst_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      valid_q       <= valid_d;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a table of post-reset cycles, directed corner sequences, then random
// traffic checked against a queue-based model of the fetch stage and a latency-driven memory.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .pc_o          (pc),
    .inst_o        (inst),
    .inst_valid_o  (inst_valid)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: buffered words, one pending fetch (possibly marked for dropping).
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_pend_pc;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;

  // Memory: one accepted request, answered after a 1..3 cycle latency.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_delay = 1;  // 0 selects a random latency per request

  function automatic bit m_req();
    return rst && !m_pend && (m_q.size() < 2) && !redirect;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          acc;
    logic [31:0] fpc;
    ent_t        e;
    if (!rst) begin
      m_q.delete();
      m_fetch_pc = RESET_PC;
      m_pend     = 1'b0;
      m_drop     = 1'b0;
      m_pc       = 32'h0;
      m_inst     = 32'h0;
      m_valid    = 1'b0;
      mem_busy   = 1'b0;
      return;
    end
    acc = m_req() && imem_ready;
    fpc = m_fetch_pc;
    if (redirect) begin
      m_q.delete();
      m_inst  = 32'h0;
      m_valid = 1'b0;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        e       = m_q.pop_front();
        m_pc    = e.pc;
        m_inst  = e.inst;
        m_valid = 1'b1;
      end else begin
        m_inst  = 32'h0;
        m_valid = 1'b0;
      end
    end
    if (m_pend && imem_rvalid) begin
      if (!m_drop && !redirect) begin
        e.pc   = m_pend_pc;
        e.inst = imem_rdata;
        m_q.push_back(e);
      end
      m_pend = 1'b0;
      m_drop = 1'b0;
    end
    if (redirect) begin
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      if (m_pend) m_drop = 1'b1;
    end else if (acc) begin
      m_pend_pc  = fpc;
      m_fetch_pc = fpc + 32'd4;
      m_pend     = 1'b1;
      m_drop     = 1'b0;
    end
    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = (mem_delay == 0) ? int'($urandom_range(2, 0)) : mem_delay - 1;
      mem_addr = fpc;
    end
  endtask

  // Called just after a rising edge: drive memory response, move to the sampling edge.
  task automatic step_begin();
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? (mem_addr ^ 32'hA5A5_0000) : $urandom();
    @(negedge clk);
  endtask

  task automatic step_end();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    check("req",   32'(imem_req),   32'(m_req()));
    check("addr",  imem_addr,       m_fetch_pc);
    check("pc",    pc,              m_pc);
    check("inst",  inst,            m_inst);
    check("valid", 32'(inst_valid), 32'(m_valid));
  endtask

  task automatic step();
    step_begin();
    check_model();
    step_end();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } vec_t;
  vec_t tbl[6];

  initial begin
    // Cycles after reset release, memory always ready with single-cycle responses.
    tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0, 32'h0000_0000, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hA5A5_0000, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0, 32'h0000_0000, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h4, 32'hA5A5_0004, 1'b1};

    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    model_edge();
    #1;

    // Reset state while rst is still low.
    step_begin();
    check("rst_req",   32'(imem_req),   32'h0);
    check("rst_addr",  imem_addr,       RESET_PC);
    check("rst_pc",    pc,              32'h0);
    check("rst_inst",  inst,            32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    step_end();
    rst = 1'b1;

    mem_delay = 1;
    for (int i = 0; i < 6; i++) begin
      stall      = tbl[i].stall;
      imem_ready = tbl[i].ready;
      step_begin();
      check($sformatf("tbl%0d_req", i),   32'(imem_req),   32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i),  imem_addr,       tbl[i].addr);
      check($sformatf("tbl%0d_pc", i),    pc,              tbl[i].pc);
      check($sformatf("tbl%0d_inst", i),  inst,            tbl[i].inst);
      check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
      step_end();
    end

    // Stall: buffer fills to two words, requests stop, outputs frozen.
    stall = 1'b1;
    repeat (5) step();
    step_begin();
    check_model();
    check("stall_req",   32'(imem_req),   32'h0);
    check("stall_valid", 32'(inst_valid), 32'h0);
    step_end();
    stall = 1'b0;
    step();
    step_begin();
    check_model();
    check("stall_rel0", inst, 32'hA5A5_0008);
    step_end();
    step_begin();
    check_model();
    check("stall_rel1", inst, 32'hA5A5_000C);
    step_end();

    // Memory not ready: address stays put.
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_begin();
      check_model();
      check("hold_req",  32'(imem_req), 32'h1);
      check("hold_addr", imem_addr,     RESET_PC);
      step_end();
    end
    imem_ready = 1'b1;

    // Redirect while a two-cycle fetch is in flight: stale word dropped.
    do_reset();
    mem_delay = 2;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    step_begin();
    check_model();
    check("redir_valid", 32'(inst_valid), 32'h0);
    check("redir_addr",  imem_addr,       32'h0000_0100);
    step_end();
    step_begin();
    check_model();
    check("redir_req", 32'(imem_req), 32'h1);
    step_end();
    repeat (3) step();
    step_begin();
    check_model();
    check("redir_pc",   pc,   32'h0000_0100);
    check("redir_inst", inst, 32'hA5A5_0100);
    step_end();

    // Redirect to the top word: fetch address wraps to zero.
    mem_delay   = 1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    repeat (3) step();  // leave any in-flight drop behind
    for (int i = 0; i < 8; i++) begin
      step_begin();
      check_model();
      if (imem_req && m_fetch_pc == 32'h0) check("wrap_addr", imem_addr, 32'h0);
      step_end();
    end

    // Reset with buffered words and a fetch in flight.
    stall     = 1'b1;
    mem_delay = 3;
    repeat (6) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step_begin();
    check_model();
    check("rrst_pc",    pc,              32'h0);
    check("rrst_inst",  inst,            32'h0);
    check("rrst_valid", 32'(inst_valid), 32'h0);
    check("rrst_addr",  imem_addr,       RESET_PC);
    step_end();
    stall = 1'b0;

    // Random traffic against the model.
    mem_delay = 0;
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(199) != 0);
      stall       = ($urandom_range(99) < 25);
      imem_ready  = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 6);
      redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15) : $urandom();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage; owns the program counter.
- Issues word fetches to instruction memory over a request/ready + response-valid handshake, with one fetch outstanding at most.
- Buffers returned words in a 2-entry {pc, inst} queue.
- Presents one instruction per cycle to decode on pc_o/inst_o; supports a decode/execute stall and a redirect (branch/jump) that flushes in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, fetch queue depth in entries; fixed at 2, and the credit logic depends on it.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-low reset; rst==0 at a rising edge resets all state.
- stall_i, input, 1, 1 = hold pc_o/inst_o/inst_valid_o; decode is not consuming this cycle.
- redirect_i, input, 1, 1 = restart fetch at redirect_pc_i; flushes the queue and the output stage.
- redirect_pc_i, input, 32, new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req_o, output, 1, fetch request valid.
- imem_addr_o, output, 32, fetch word address; equals fetch_pc.
- imem_ready_i, input, 1, memory accepts the request this cycle when imem_req_o is also 1.
- imem_rvalid_i, input, 1, response word valid; arrives ≥1 cycle after acceptance, in order.
- imem_rdata_i, input, 32, response instruction word.
- pc_o, output, 32, PC of instruction presented to decode.
- inst_o, output, 32, instruction to decode; 32'h0 (NOP) when no valid instruction.
- inst_valid_o, output, 1, inst_o holds a real fetched instruction.

Behaviour:
- Reset (rst==0 at edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; state=REQ.
  - pc_o=0, inst_o=0, inst_valid_o=0.
  - imem_req_o forced 0 while rst==0; imem_addr_o=fetch_pc.
  - Reset mid-transaction: any later imem_rvalid_i belonging to a pre-reset request is ignored while state≠WAIT/DROP (state is REQ after reset). Memory is reset in the same cycle by system design.
- Credit: imem_req_o=1 only in state REQ when (queue count + outstanding) < 2 and redirect_i==0.
- FSM:
  - REQ: on imem_req_o & imem_ready_i, fetch_pc<=fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding<=1, go WAIT. Otherwise stay in REQ with fetch_pc held, so imem_addr_o is stable while waiting.
  - WAIT: on imem_rvalid_i, push {fetch_pc_of_request, imem_rdata_i} into the queue, outstanding<=0, go REQ.
  - DROP: on imem_rvalid_i, discard the word, outstanding<=0, go REQ.
- Requested PC is kept in a req_pc register captured at acceptance.
- Output stage:
  - At an edge with stall_i==0 and redirect_i==0:
    - If queue non-empty, pop the head into pc_o/inst_o and set inst_valid_o=1.
    - Else inst_o<=0, inst_valid_o<=0, pc_o holds.
  - stall_i==1: pc_o/inst_o/inst_valid_o and queue contents held; fetch continues until credit runs out.
- Latency: a word accepted into the queue at edge N appears on inst_o after edge N+1, provided the queue was empty and there is no stall. There is no rvalid→inst_o bypass.
- Simultaneous push and pop in one cycle is legal; count is unchanged. Push when count==2 cannot occur, because credit prevents it.
- Redirect (priority over stall and all other events):
  - Queue cleared; inst_o<=0; inst_valid_o<=0; pc_o holds.
  - fetch_pc<={redirect_pc_i[31:2],2'b00}.
  - If in WAIT, or in REQ with an acceptance this cycle (impossible, since req is masked by redirect_i): go DROP. A WAIT-state rvalid in the same cycle as a redirect is discarded and the FSM goes to REQ.
  - If in REQ: stay in REQ; the new address is requested next cycle.
  - If in DROP: stay in DROP.
- Back-to-back redirects: the last one wins; at most one response is dropped per outstanding request.

Test Plan:
- Reset release, imem_ready_i=1, 1-cycle rvalid returning addr^32'hA5A5_0000: imem_addr_o sequence is 0x0, 0x4, 0x8. inst_o shows 0xA5A5_0000 (pc 0x0), then 0xA5A5_0004 (pc 0x4), with inst_valid_o=1 and bubbles between fetches.
- stall_i held 5 cycles with memory always ready: exactly 2 words queued, imem_req_o drops to 0, outputs frozen. On release, the queued words appear on consecutive cycles in order.
- imem_ready_i=0 for 3 cycles with imem_req_o=1: imem_addr_o is stable at the same value; fetch_pc does not advance.
- redirect_i=1 with redirect_pc_i=0x0000_0103 while in WAIT (rvalid delayed 2 cycles): the stale word is discarded and never reaches inst_o. The next request address is 0x0000_0100, and inst_valid_o=0 on the cycle after the redirect.
- Redirect to 0xFFFF_FFFC: requests go 0xFFFF_FFFC then 0x0000_0000 (wrap).
- rst=0 asserted while in WAIT with 2 queued words: the next cycle has all outputs 0, the queue is empty, and the first request after release is RESET_PC.
